// File: rtl/z80fi_pkg.sv
// Purpose : shared types for the Z80FI retirement-record collector.
// Latency : n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: cycle_type_t M-cycle encoding, z80fi_regs_t architectural snapshot,
//           collector FSM state, saturating 3-bit T-state increment.
package z80fi_pkg;

   typedef enum logic [2:0] {
      CYCLE_NONE     = 3'd0,
      CYCLE_M1       = 3'd1,
      CYCLE_MEM_RD   = 3'd2,
      CYCLE_MEM_WR   = 3'd3,
      CYCLE_IO_RD    = 3'd4,
      CYCLE_IO_WR    = 3'd5,
      CYCLE_INTERNAL = 3'd6
   } cycle_type_t;

   // Main set, alternate set, index/stack/program pointers, I and R.
   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  f;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [7:0]  d;
      logic [7:0]  e;
      logic [7:0]  h;
      logic [7:0]  l;
      logic [7:0]  a2;
      logic [7:0]  f2;
      logic [7:0]  b2;
      logic [7:0]  c2;
      logic [7:0]  d2;
      logic [7:0]  e2;
      logic [7:0]  h2;
      logic [7:0]  l2;
      logic [15:0] ix;
      logic [15:0] iy;
      logic [15:0] sp;
      logic [15:0] ip;
      logic [7:0]  i;
      logic [7:0]  r;
   } z80fi_regs_t;

   localparam int Z80FI_REGS_W = $bits(z80fi_regs_t);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_EMIT    = 2'd2
   } collector_state_t;

   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/z80fi_mcycle_tracker.sv
// Purpose : per-instruction M-cycle slot list: type and saturating T-state count per slot.
// Latency : slot state updates on the clock the strobes are sampled.
// Backpressure: none; M-cycles beyond the last slot are dropped and flagged.
// Ports   : start opens slot 0 with mcycle_type; step marks a capture clock in which
//           mcycle_start opens the next slot, otherwise the current slot counts a T-state.
//           slot_type / slot_tcycles are 3 bits per slot, slot k at [3k+:3]; overflow sticky.
module z80fi_mcycle_tracker
   import z80fi_pkg::*;
#(
   parameter int MAX_MCYCLES = 6
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     step,
   input  logic                     mcycle_start,
   input  logic [2:0]               mcycle_type,
   output logic [3*MAX_MCYCLES-1:0] slot_type,
   output logic [3*MAX_MCYCLES-1:0] slot_tcycles,
   output logic                     overflow
);

   localparam int IDX_W = (MAX_MCYCLES > 1) ? $clog2(MAX_MCYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(MAX_MCYCLES - 1);

   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx          <= '0;
         slot_type    <= {MAX_MCYCLES{3'(CYCLE_NONE)}};
         slot_tcycles <= '0;
         overflow     <= 1'b0;
      end else if (start) begin
         idx               <= '0;
         overflow          <= 1'b0;
         slot_type         <= {MAX_MCYCLES{3'(CYCLE_NONE)}};
         slot_type[2:0]    <= mcycle_type;
         slot_tcycles      <= '0;
         slot_tcycles[2:0] <= 3'd1;
      end else if (step) begin
         if (mcycle_start) begin
            if (idx == LAST_SLOT) begin
               overflow <= 1'b1;
            end else begin
               idx                                <= idx + IDX_W'(1);
               slot_type[3*(int'(idx)+1) +: 3]    <= mcycle_type;
               slot_tcycles[3*(int'(idx)+1) +: 3] <= 3'd1;
            end
         end else if (!overflow) begin
            // Once an M-cycle has been dropped, its T-states must not be
            // credited to the last recorded slot.
            slot_tcycles[3*int'(idx) +: 3] <= sat_inc3(slot_tcycles[3*int'(idx) +: 3]);
         end
      end
   end

endmodule

// File: rtl/z80fi_collector.sv
// Purpose : builds one Z80FI retirement record per executed instruction from core strobes.
// Latency : insn_done at clk N -> regs_out sampled at N+1 -> z80fi_valid pulse at N+2.
// Backpressure: none; consumers sample on z80fi_valid, record outputs hold until next emit.
// Ports   : clk/reset_n (sync, active-low); insn_start, mcycle_start, mcycle_type,
//           opcode_valid/opcode_byte, insn_done, regs in; z80fi_valid, z80fi_insn,
//           z80fi_insn_len, z80fi_regs_in/out, z80fi_mcycle_type, z80fi_tcycles, z80fi_error out.
module z80fi_collector
   import z80fi_pkg::*;
#(
   parameter int MAX_INSN_BYTES = 4,
   parameter int MAX_MCYCLES    = 6,
   parameter int REGS_W         = Z80FI_REGS_W
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        insn_start,
   input  logic                        mcycle_start,
   input  logic [2:0]                  mcycle_type,
   input  logic                        opcode_valid,
   input  logic [7:0]                  opcode_byte,
   input  logic                        insn_done,
   input  logic [REGS_W-1:0]           regs,
   output logic                        z80fi_valid,
   output logic [8*MAX_INSN_BYTES-1:0] z80fi_insn,
   output logic [2:0]                  z80fi_insn_len,
   output logic [REGS_W-1:0]           z80fi_regs_in,
   output logic [REGS_W-1:0]           z80fi_regs_out,
   output logic [3*MAX_MCYCLES-1:0]    z80fi_mcycle_type,
   output logic [3*MAX_MCYCLES-1:0]    z80fi_tcycles,
   output logic                        z80fi_error
);

   localparam logic [2:0] LEN_MAX = 3'(MAX_INSN_BYTES);

   collector_state_t state;

   // Working set for the instruction in flight; kept apart from the record
   // outputs so an emit can overlap the next instruction's first clock.
   logic [8*MAX_INSN_BYTES-1:0] w_insn;
   logic [2:0]                  w_len;
   logic [REGS_W-1:0]           w_regs_in;
   logic                        w_byte_ovf;
   logic [3*MAX_MCYCLES-1:0]    w_types;
   logic [3*MAX_MCYCLES-1:0]    w_tcycles;
   logic                        w_mc_ovf;

   logic accept_start;
   logic capture_clk;

   // insn_done wins over a simultaneous insn_start while capturing. A start
   // in CAPTURE without done abandons the record and restarts capture.
   assign accept_start = insn_start && !(state == ST_CAPTURE && insn_done);
   assign capture_clk  = (state == ST_CAPTURE) && !accept_start;

   z80fi_mcycle_tracker #(
      .MAX_MCYCLES (MAX_MCYCLES)
   ) u_tracker (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (accept_start),
      .step         (capture_clk),
      .mcycle_start (mcycle_start),
      .mcycle_type  (mcycle_type),
      .slot_type    (w_types),
      .slot_tcycles (w_tcycles),
      .overflow     (w_mc_ovf)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         w_insn            <= '0;
         w_len             <= '0;
         w_regs_in         <= '0;
         w_byte_ovf        <= 1'b0;
         z80fi_valid       <= 1'b0;
         z80fi_insn        <= '0;
         z80fi_insn_len    <= '0;
         z80fi_regs_in     <= '0;
         z80fi_regs_out    <= '0;
         z80fi_mcycle_type <= {MAX_MCYCLES{3'(CYCLE_NONE)}};
         z80fi_tcycles     <= '0;
         z80fi_error       <= 1'b0;
      end else begin
         z80fi_valid <= 1'b0;

         if (state == ST_EMIT) begin
            z80fi_valid       <= 1'b1;
            z80fi_insn        <= w_insn;
            z80fi_insn_len    <= w_len;
            z80fi_regs_in     <= w_regs_in;
            z80fi_regs_out    <= regs;
            z80fi_mcycle_type <= w_types;
            z80fi_tcycles     <= w_tcycles;
            z80fi_error       <= w_byte_ovf | w_mc_ovf;
         end

         if (accept_start) begin
            state      <= ST_CAPTURE;
            w_regs_in  <= regs;
            w_byte_ovf <= 1'b0;
            w_insn     <= '0;
            if (opcode_valid) begin
               w_insn[7:0] <= opcode_byte;
               w_len       <= 3'd1;
            end else begin
               w_len <= 3'd0;
            end
         end else begin
            case (state)
               ST_CAPTURE: begin
                  if (opcode_valid) begin
                     if (w_len == LEN_MAX) begin
                        w_byte_ovf <= 1'b1;
                     end else begin
                        w_insn[8*int'(w_len) +: 8] <= opcode_byte;
                        w_len                      <= w_len + 3'd1;
                     end
                  end
                  if (insn_done) begin
                     state <= ST_EMIT;
                  end
               end
               ST_EMIT: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_z80fi_collector.sv
// Purpose : directed bench for z80fi_collector with an instruction-level reference model.
// Latency : expects z80fi_valid exactly two clocks after each completed insn_done.
// Backpressure: n/a.
module tb_z80fi_collector;
   import z80fi_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         insn_start = 1'b0;
   logic         mcycle_start = 1'b0;
   logic [2:0]   mcycle_type = 3'd0;
   logic         opcode_valid = 1'b0;
   logic [7:0]   opcode_byte = 8'd0;
   logic         insn_done = 1'b0;
   logic [207:0] regs = '0;

   logic         z80fi_valid;
   logic [31:0]  z80fi_insn;
   logic [2:0]   z80fi_insn_len;
   logic [207:0] z80fi_regs_in;
   logic [207:0] z80fi_regs_out;
   logic [17:0]  z80fi_mcycle_type;
   logic [17:0]  z80fi_tcycles;
   logic         z80fi_error;

   z80fi_collector dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .insn_start        (insn_start),
      .mcycle_start      (mcycle_start),
      .mcycle_type       (mcycle_type),
      .opcode_valid      (opcode_valid),
      .opcode_byte       (opcode_byte),
      .insn_done         (insn_done),
      .regs              (regs),
      .z80fi_valid       (z80fi_valid),
      .z80fi_insn        (z80fi_insn),
      .z80fi_insn_len    (z80fi_insn_len),
      .z80fi_regs_in     (z80fi_regs_in),
      .z80fi_regs_out    (z80fi_regs_out),
      .z80fi_mcycle_type (z80fi_mcycle_type),
      .z80fi_tcycles     (z80fi_tcycles),
      .z80fi_error       (z80fi_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Instruction description: M-cycles (type, length) and fetched bytes
   // with the T-state (from instruction start) at which each is fetched.
   int          n_mc;
   logic [2:0]  mc_type [0:15];
   int          mc_len  [0:15];
   int          n_bytes;
   logic [7:0]  bytes   [0:7];
   int          byte_t  [0:7];

   task automatic clear_desc();
      n_mc = 0;
      n_bytes = 0;
   endtask

   task automatic add_mc(input logic [2:0] t, input int len);
      mc_type[n_mc] = t;
      mc_len[n_mc]  = len;
      n_mc++;
   endtask

   task automatic add_byte(input logic [7:0] b, input int t);
      bytes[n_bytes]  = b;
      byte_t[n_bytes] = t;
      n_bytes++;
   endtask

   typedef struct {
      int          due;
      int          rin_k;
      logic [31:0] insn;
      logic [2:0]  len;
      logic [17:0] types;
      logic [17:0] tcyc;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   bit           hold_regs = 1'b0;
   logic [207:0] cur_regs = '0;
   logic [207:0] reg_hist [0:4095];

   function automatic logic [207:0] rand_regs();
      logic [207:0] r;
      r = '0;
      for (int i = 0; i < 7; i++) r = {r[175:0], 32'($urandom())};
      return r;
   endfunction

   // Record the instruction must produce, from the architectural rules:
   // first four bytes kept, first six M-cycles kept, T counts cap at 7.
   function automatic exp_t model(input int due, input int rin_k);
      exp_t e;
      int   nb;
      int   nm;
      e.due   = due;
      e.rin_k = rin_k;
      e.insn  = '0;
      e.types = '0;
      e.tcyc  = '0;
      nb = (n_bytes < 4) ? n_bytes : 4;
      e.len = 3'(nb);
      for (int i = 0; i < nb; i++) e.insn[8*i +: 8] = bytes[i];
      nm = (n_mc < 6) ? n_mc : 6;
      for (int s = 0; s < nm; s++) begin
         e.types[3*s +: 3] = mc_type[s];
         e.tcyc[3*s +: 3]  = 3'((mc_len[s] > 7) ? 7 : mc_len[s]);
      end
      e.err = (n_bytes > 4) || (n_mc > 6);
      return e;
   endfunction

   // Drives one clock of stimulus; k is the clock number at which it is sampled.
   task automatic tick(input logic st, input logic ms, input logic [2:0] mt,
                       input logic ov, input logic [7:0] ob, input logic dn, output int k);
      @(negedge clk);
      k = cyc + 1;
      reset_n      = 1'b1;
      insn_start   = st;
      mcycle_start = ms;
      mcycle_type  = mt;
      opcode_valid = ov;
      opcode_byte  = ob;
      insn_done    = dn;
      if (!hold_regs) cur_regs = rand_regs();
      regs = cur_regs;
      reg_hist[k] = cur_regs;
   endtask

   task automatic idle(input int n);
      int k;
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, k);
   endtask

   task automatic do_reset(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         tick(1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, k);
         reset_n = 1'b0;
      end
      exp_q.delete();
   endtask

   // Drives the described instruction; stops after 'cut' T-states. Only a
   // fully driven instruction raises insn_done and expects a record.
   task automatic drive_insn(input int cut);
      int total, k, start_k, mc, mc_t, bi;
      logic ms, ov;
      logic [2:0] mt;
      logic [7:0] ob;
      total = 0;
      for (int i = 0; i < n_mc; i++) total += mc_len[i];
      mc = 0; mc_t = 0; bi = 0; k = 0; start_k = 0;
      for (int t = 0; t < total && t < cut; t++) begin
         if (mc_t == mc_len[mc]) begin
            mc++;
            mc_t = 0;
         end
         ms = (mc_t == 0);
         mt = ms ? mc_type[mc] : 3'd0;
         ov = (bi < n_bytes) && (byte_t[bi] == t);
         ob = ov ? bytes[bi] : 8'h00;
         if (ov) bi++;
         tick(t == 0, ms, mt, ov, ob, (cut >= total) && (t == total - 1), k);
         if (t == 0) start_k = k;
         mc_t++;
      end
      if (cut >= total) exp_q.push_back(model(k + 2, start_k));
   endtask

   // Compare process: every clock, valid must match the model's schedule;
   // on a valid clock every record field must match the model.
   bit   chk_en = 1'b0;
   int   valid_log[$];
   int   ck;
   exp_t ce;

   always @(negedge clk) begin
      if (chk_en) begin
         ck = cyc + 1;
         if (z80fi_valid === 1'b1) valid_log.push_back(ck);
         if (exp_q.size() > 0 && exp_q[0].due == ck) begin
            ce = exp_q.pop_front();
            check("rec_valid",   z80fi_valid, 1'b1);
            check("rec_insn",    z80fi_insn, ce.insn);
            check("rec_len",     z80fi_insn_len, ce.len);
            check("rec_types",   z80fi_mcycle_type, ce.types);
            check("rec_tcycles", z80fi_tcycles, ce.tcyc);
            check("rec_error",   z80fi_error, ce.err);
            check("rec_regs_in", z80fi_regs_in, reg_hist[ce.rin_k]);
            check("rec_regs_out", z80fi_regs_out, reg_hist[ce.due - 1]);
         end else begin
            check("valid_idle", z80fi_valid, 1'b0);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   z80fi_valid, 0);
      check({tag, "_insn"},    z80fi_insn, 0);
      check({tag, "_len"},     z80fi_insn_len, 0);
      check({tag, "_regs_in"}, z80fi_regs_in, 0);
      check({tag, "_regs_out"}, z80fi_regs_out, 0);
      check({tag, "_types"},   z80fi_mcycle_type, 0);
      check({tag, "_tcycles"}, z80fi_tcycles, 0);
      check({tag, "_error"},   z80fi_error, 0);
   endtask

   z80fi_regs_t base, swapped, ri, ro;

   initial begin
      do_reset(3);
      idle(1);
      check_all_zero("reset");
      chk_en = 1'b1;

      // EX DE,HL: single-byte M1 of 4 T-states, DE/HL swapped after retirement.
      clear_desc();
      add_mc(CYCLE_M1, 4);
      add_byte(8'hEB, 1);
      base = rand_regs();
      base.d = 8'h12; base.e = 8'h34; base.h = 8'h56; base.l = 8'h78;
      swapped = base;
      swapped.d = base.h; swapped.e = base.l; swapped.h = base.d; swapped.l = base.e;
      hold_regs = 1'b1;
      cur_regs = base;
      drive_insn(99);
      cur_regs = swapped;
      idle(4);
      hold_regs = 1'b0;
      ri = z80fi_regs_in;
      ro = z80fi_regs_out;
      check("ex_len",    z80fi_insn_len, 1);
      check("ex_insn",   z80fi_insn, 32'h0000_00EB);
      check("ex_type0",  z80fi_mcycle_type[2:0], CYCLE_M1);
      check("ex_t0",     z80fi_tcycles[2:0], 4);
      check("ex_slot1",  {z80fi_mcycle_type[5:3], z80fi_tcycles[5:3]}, 0);
      check("ex_de_in",  {ri.d, ri.e}, 16'h1234);
      check("ex_de_out", {ro.d, ro.e}, 16'h5678);
      check("ex_hl_out", {ro.h, ro.l}, 16'h1234);

      // LD A,(nn) 3A 34 12.
      clear_desc();
      add_mc(CYCLE_M1, 4); add_mc(CYCLE_MEM_RD, 3); add_mc(CYCLE_MEM_RD, 3); add_mc(CYCLE_MEM_RD, 3);
      add_byte(8'h3A, 1); add_byte(8'h34, 5); add_byte(8'h12, 8);
      drive_insn(99);
      idle(3);
      check("ld_insn",  z80fi_insn, 32'h0012_343A);
      check("ld_len",   z80fi_insn_len, 3);
      check("ld_tcyc",  z80fi_tcycles, 18'o003334);
      check("ld_types", z80fi_mcycle_type, 18'o002221);
      check("ld_error", z80fi_error, 0);

      // Back-to-back NOP,NOP: second insn_start lands on the EMIT clock.
      valid_log.delete();
      clear_desc();
      add_mc(CYCLE_M1, 4);
      add_byte(8'h00, 1);
      drive_insn(99);
      drive_insn(99);
      idle(4);
      check("b2b_pulses", valid_log.size(), 2);
      if (valid_log.size() == 2) check("b2b_gap", valid_log[1] - valid_log[0], 4);

      // Five bytes DD CB 05 C6 00: fifth byte dropped.
      clear_desc();
      add_mc(CYCLE_M1, 4); add_mc(CYCLE_M1, 4); add_mc(CYCLE_MEM_RD, 3);
      add_mc(CYCLE_MEM_RD, 3); add_mc(CYCLE_MEM_RD, 3);
      add_byte(8'hDD, 1); add_byte(8'hCB, 5); add_byte(8'h05, 9);
      add_byte(8'hC6, 12); add_byte(8'h00, 15);
      drive_insn(99);
      idle(3);
      check("ovb_len",   z80fi_insn_len, 4);
      check("ovb_error", z80fi_error, 1);
      check("ovb_insn",  z80fi_insn, 32'hC605_CBDD);

      // Seven M-cycles: seventh dropped, slot 5 holds the sixth.
      clear_desc();
      add_mc(CYCLE_M1, 4); add_mc(CYCLE_MEM_RD, 3); add_mc(CYCLE_MEM_WR, 3);
      add_mc(CYCLE_IO_RD, 4); add_mc(CYCLE_IO_WR, 4); add_mc(CYCLE_INTERNAL, 5);
      add_mc(CYCLE_MEM_RD, 3);
      add_byte(8'h00, 1);
      drive_insn(99);
      idle(3);
      check("ovm_error", z80fi_error, 1);
      check("ovm_type5", z80fi_mcycle_type[17:15], CYCLE_INTERNAL);
      check("ovm_tcyc",  z80fi_tcycles, 18'o544334);
      check("ovm_len",   z80fi_insn_len, 1);

      // Reset mid-capture: no record, outputs cleared.
      clear_desc();
      add_mc(CYCLE_M1, 4); add_mc(CYCLE_MEM_RD, 3);
      add_byte(8'h3A, 1);
      drive_insn(3);
      do_reset(1);
      idle(1);
      check_all_zero("midrst");
      clear_desc();
      add_mc(CYCLE_M1, 4);
      add_byte(8'h00, 1);
      drive_insn(99);
      idle(3);
      check("postrst_len",  z80fi_insn_len, 1);
      check("postrst_tcyc", z80fi_tcycles, 18'o000004);

      // insn_start mid-capture: first abandoned, second recorded cleanly.
      clear_desc();
      add_mc(CYCLE_M1, 4); add_mc(CYCLE_MEM_RD, 3);
      add_byte(8'h3A, 1); add_byte(8'h55, 4);
      drive_insn(5);
      clear_desc();
      add_mc(CYCLE_M1, 4); add_mc(CYCLE_MEM_RD, 3);
      add_byte(8'h06, 1); add_byte(8'h77, 5);
      drive_insn(99);
      idle(3);
      check("restart_insn",  z80fi_insn, 32'h0000_7706);
      check("restart_len",   z80fi_insn_len, 2);
      check("restart_types", z80fi_mcycle_type, 18'o000021);
      check("restart_error", z80fi_error, 0);

      // HALT-style 9-T M1: T count saturates at 7.
      clear_desc();
      add_mc(CYCLE_M1, 9);
      add_byte(8'h76, 1);
      drive_insn(99);
      idle(3);
      check("halt_tcyc", z80fi_tcycles, 18'o000007);

      idle(4);
      check("queue_drained", exp_q.size(), 0);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
